// File: rtl/fixed_point_pkg.sv
// Shared fixed-point helpers: FSM state type, ONE constant, range check and fit.
// ACT_GRAD_SATURATE_EN selects clamping in fx_fit; otherwise values wrap.
package fixed_point_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SQ,
    ST_SUB,
    ST_SC,
    ST_OUT
  } state_e;

  // Wide signed scratch type; holds any 2*WIDTH+1 bit intermediate for WIDTH <= 31.
  localparam int FX_MAXW = 64;
  typedef logic signed [FX_MAXW-1:0] fx_wide_t;

  function automatic int fx_one(input int frac_bits);
    return 1 << frac_bits;
  endfunction

  function automatic logic fx_ovf(input fx_wide_t v, input int w);
    fx_wide_t hi, lo;
    hi = (fx_wide_t'(1) <<< (w - 1)) - fx_wide_t'(1);
    lo = -(fx_wide_t'(1) <<< (w - 1));
    return (v > hi) || (v < lo);
  endfunction

  // Brings v into the signed w-bit range, returned sign-extended.
  function automatic fx_wide_t fx_fit(input fx_wide_t v, input int w);
`ifdef ACT_GRAD_SATURATE_EN
    fx_wide_t hi, lo;
    hi = (fx_wide_t'(1) <<< (w - 1)) - fx_wide_t'(1);
    lo = -(fx_wide_t'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    return (v <<< (FX_MAXW - w)) >>> (FX_MAXW - w);
`endif
  endfunction

endpackage

// File: rtl/fixed_point_seq_mul.sv
// Unsigned radix-2 shift-add multiplier; DONE pulses exactly WIDTH cycles after START.
// Bit 0 of B is consumed on the START edge itself, the remaining WIDTH-1 bits after it.
module fixed_point_seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               START,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               DONE,
  output logic [2*WIDTH-1:0] P
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;

  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (START) begin
      acc_d   = B[0] ? {{WIDTH{1'b0}}, A} : '0;
      mcand_d = {{(WIDTH-1){1'b0}}, A, 1'b0};
      mplr_d  = B >> 1;
      cnt_d   = CW'(WIDTH - 1);
      busy_d  = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        if (mplr_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign DONE = busy_q && (cnt_q == '0);
  assign P    = acc_q;

endmodule

// File: rtl/fixed_point_act_fun_grad.sv
// tanh backward step: VALUE_OUT = g * (1 - y^2), one shared sequential multiplier.
// ACT_GRAD_SATURATE_EN clamps overflowing values; default build wraps.
module fixed_point_act_fun_grad
  import fixed_point_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 13
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] VALUE_IN,
  input  logic [WIDTH-1:0] GRAD_IN,
  input  logic             VALID_IN,
  output logic             READY_OUT,
  output logic [WIDTH-1:0] VALUE_OUT,
  output logic             VALID_OUT,
  input  logic             READY_IN,
  output logic             OVERFLOW
);

  localparam fx_wide_t         ONE_W = fx_wide_t'(fx_one(FRAC_BITS));
  localparam logic [WIDTH-1:0] ONE_U = WIDTH'(fx_one(FRAC_BITS));

  state_e             state_q;
  logic [WIDTH-1:0]   g_q, p1_q, d_q, value_q;
  logic               valid_q, ovf_q, sc_start_q;

  logic               accept, sc_phase, mul_start, mul_done;
  logic [WIDTH-1:0]   y_abs, g_abs, d_abs, mul_a, mul_b;
  logic [2*WIDTH-1:0] mul_p;
  fx_wide_t           sq_w, diff_w, prod_w, res_w;
  logic [WIDTH-1:0]   p1_d, d_d, res_d;
  logic               y_ovf, p1_ovf, d_ovf, res_ovf;

  always_comb begin
    accept   = (state_q == ST_IDLE) && VALID_IN;
    sc_phase = (state_q == ST_SC);
    y_abs    = VALUE_IN[WIDTH-1] ? -VALUE_IN : VALUE_IN;
    g_abs    = g_q[WIDTH-1] ? -g_q : g_q;
    d_abs    = d_q[WIDTH-1] ? -d_q : d_q;
    y_ovf    = y_abs > ONE_U;

    // The square is launched straight off the input on the accepting edge;
    // the scaling product starts from registered operands in the first SC cycle.
    mul_start = accept | sc_start_q;
    mul_a     = sc_phase ? g_abs : y_abs;
    mul_b     = sc_phase ? d_abs : y_abs;

    sq_w   = fx_wide_t'(mul_p) >>> FRAC_BITS;
    p1_ovf = fx_ovf(sq_w, WIDTH);
    p1_d   = WIDTH'(fx_fit(sq_w, WIDTH));

    diff_w = ONE_W - fx_wide_t'($signed(p1_q));
    d_ovf  = fx_ovf(diff_w, WIDTH);
    d_d    = WIDTH'(fx_fit(diff_w, WIDTH));

    prod_w  = fx_wide_t'(mul_p);
    res_w   = ((g_q[WIDTH-1] ^ d_q[WIDTH-1]) ? -prod_w : prod_w) >>> FRAC_BITS;
    res_ovf = fx_ovf(res_w, WIDTH);
    res_d   = WIDTH'(fx_fit(res_w, WIDTH));
  end

  fixed_point_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .START (mul_start),
    .A     (mul_a),
    .B     (mul_b),
    .DONE  (mul_done),
    .P     (mul_p)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= ST_IDLE;
      g_q        <= '0;
      p1_q       <= '0;
      d_q        <= '0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      sc_start_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            g_q     <= GRAD_IN;
            ovf_q   <= y_ovf;
            state_q <= ST_SQ;
          end
        end
        ST_SQ: begin
          if (mul_done) begin
            p1_q    <= p1_d;
            ovf_q   <= ovf_q | p1_ovf;
            state_q <= ST_SUB;
          end
        end
        ST_SUB: begin
          d_q        <= d_d;
          ovf_q      <= ovf_q | d_ovf;
          sc_start_q <= 1'b1;
          state_q    <= ST_SC;
        end
        ST_SC: begin
          sc_start_q <= 1'b0;
          if (mul_done) begin
            value_q <= res_d;
            valid_q <= 1'b1;
            ovf_q   <= ovf_q | res_ovf;
            state_q <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (READY_IN) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign READY_OUT = RSTN && (state_q == ST_IDLE);
  assign VALUE_OUT = value_q;
  assign VALID_OUT = valid_q;
  assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_fixed_point_act_fun_grad.sv
// Directed + random bench for fixed_point_act_fun_grad with a result scoreboard.
// Expected values follow ACT_GRAD_SATURATE_EN the same way the design build does.
module tb_fixed_point_act_fun_grad;

  localparam int     W    = 16;
  localparam int     FRAC = 13;
  localparam longint ONE  = 64'sd8192;
  localparam int     LAT  = 2 * W + 2;

  typedef struct packed {
    logic         ovf;
    logic [W-1:0] val;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RSTN = 1'b1;
  logic [W-1:0] VALUE_IN = '0;
  logic [W-1:0] GRAD_IN = '0;
  logic         VALID_IN = 1'b0;
  logic         READY_IN = 1'b0;
  logic         READY_OUT, VALID_OUT, OVERFLOW;
  logic [W-1:0] VALUE_OUT;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  fixed_point_act_fun_grad #(.WIDTH(W), .FRAC_BITS(FRAC)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .VALUE_IN  (VALUE_IN),
    .GRAD_IN   (GRAD_IN),
    .VALID_IN  (VALID_IN),
    .READY_OUT (READY_OUT),
    .VALUE_OUT (VALUE_OUT),
    .VALID_OUT (VALID_OUT),
    .READY_IN  (READY_IN),
    .OVERFLOW  (OVERFLOW)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic out_of_range(input longint v);
    return (v > 64'sd32767) || (v < -64'sd32768);
  endfunction

  function automatic longint fit(input longint v);
`ifdef ACT_GRAD_SATURATE_EN
    if (v > 64'sd32767) return 64'sd32767;
    if (v < -64'sd32768) return -64'sd32768;
    return v;
`else
    return longint'(shortint'(v));
`endif
  endfunction

  // Reference: exact integer arithmetic, floor shifts, range check at each step.
  function automatic exp_t model(input logic [W-1:0] y, input logic [W-1:0] g);
    longint yv, gv, ya, p1, d, r;
    exp_t   e;
    yv    = longint'($signed(y));
    gv    = longint'($signed(g));
    ya    = (yv < 0) ? -yv : yv;
    e.ovf = ya > ONE;
    p1    = (ya * ya) >>> FRAC;
    e.ovf = e.ovf | out_of_range(p1);
    p1    = fit(p1);
    d     = ONE - p1;
    e.ovf = e.ovf | out_of_range(d);
    d     = fit(d);
    r     = (gv * d) >>> FRAC;
    e.ovf = e.ovf | out_of_range(r);
    r     = fit(r);
    e.val = r[W-1:0];
    return e;
  endfunction

  task automatic do_op(input logic [W-1:0] y, input logic [W-1:0] g, input int hold,
                       input string tag);
    int   waited, lat;
    exp_t e;
    @(negedge CLK);
    waited = 0;
    while (!READY_OUT && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    check({tag, " ready_in_idle"}, 32'(READY_OUT), 32'd1);
    VALUE_IN = y;
    GRAD_IN  = g;
    VALID_IN = 1'b1;
    READY_IN = (hold == 0);
    sb.push_back(model(y, g));
    @(posedge CLK);
    #1 VALID_IN = 1'b0;
    lat = 0;
    while (!VALID_OUT && lat < 200) begin
      @(posedge CLK);
      #1;
      lat++;
      if (lat == 5) check({tag, " busy_not_ready"}, 32'(READY_OUT), 32'd0);
    end
    check({tag, " latency"}, 32'(lat), 32'(LAT));
    e = sb.pop_front();
    check({tag, " value"}, 32'(VALUE_OUT), 32'(e.val));
    check({tag, " ovf"}, 32'(OVERFLOW), 32'(e.ovf));
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK);
      #1;
      check({tag, " hold_valid"}, 32'(VALID_OUT), 32'd1);
      check({tag, " hold_value"}, 32'(VALUE_OUT), 32'(e.val));
      check({tag, " hold_ready"}, 32'(READY_OUT), 32'd0);
    end
    READY_IN = 1'b1;
    @(posedge CLK);
    #1;
    check({tag, " consumed"}, 32'(VALID_OUT), 32'd0);
    check({tag, " back_idle"}, 32'(READY_OUT), 32'd1);
    READY_IN = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ry, rg;
    #2 RSTN = 1'b0;
    #1;
    check("rst value", 32'(VALUE_OUT), 32'd0);
    check("rst valid", 32'(VALID_OUT), 32'd0);
    check("rst ovf", 32'(OVERFLOW), 32'd0);
    check("rst ready", 32'(READY_OUT), 32'd0);
    repeat (3) @(negedge CLK);
    RSTN = 1'b1;
    #1 check("ready after rst", 32'(READY_OUT), 32'd1);

    do_op(16'h0000, 16'h2000, 0, "y0");
    do_op(16'h1000, 16'h2000, 0, "yhalf");
    do_op(16'hF000, 16'h2000, 0, "yneghalf");
    do_op(16'h1000, 16'hC000, 0, "gneg");
    do_op(16'h2000, 16'h1234, 0, "yone");
    do_op(16'hE000, 16'h7FFF, 0, "ynegone");
    do_op(16'h4000, 16'h2000, 0, "ybig");
    do_op(16'h8000, 16'h8000, 0, "ymin");
    do_op(16'h0800, 16'hFFFF, 0, "tinyneg");
    do_op(16'h1000, 16'h2000, 10, "stall");

    // Abort an operation while the scaling product is running.
    @(negedge CLK);
    VALUE_IN = 16'h4000;
    GRAD_IN  = 16'h2000;
    VALID_IN = 1'b1;
    @(posedge CLK);
    #1 VALID_IN = 1'b0;
    repeat (25) @(posedge CLK);
    #1;
    check("pre-abort busy", 32'(READY_OUT), 32'd0);
    check("pre-abort ovf", 32'(OVERFLOW), 32'd1);
    #2 RSTN = 1'b0;
    #1;
    check("abort value", 32'(VALUE_OUT), 32'd0);
    check("abort valid", 32'(VALID_OUT), 32'd0);
    check("abort ovf", 32'(OVERFLOW), 32'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    #1 check("abort ready", 32'(READY_OUT), 32'd1);
    do_op(16'h1000, 16'hC000, 0, "post-abort");

    for (int i = 0; i < 6; i++) begin
      ry = W'($urandom_range(0, 16384) - 8192);
      rg = W'($urandom);
      do_op(ry, rg, i % 3, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
